pe_lane_stream_bridge: RTL and testbench

Parametrised, multi-lane stream bridge between the system-side lane interface and the PE array lanes. Each lane gets its own FIFO, a stream-framing checker and an enable/flush control driven from the OOB path. It replaces the fixed single-width lane connection, generalising lane count, data width and buffer depth, and adds protocol-error detection that the original path did not have.

---
 rtl/pe_lane_stream_bridge.sv | 161 ++++++++++++++++
 tb/tb_pe_lane_stream_bridge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_lane_stream_bridge.sv
// Per-lane stream bridge: FIFO + framing check + OOB enable/flush; optional PE_LANE_BRIDGE_STATS_EN.
// Latency 1 cycle accept-to-valid; input ready is count<DEPTH from registers only, output holds until PE ready.

module pe_lane_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop_rdy,
  output logic                         out_vld,
  output logic [W-1:0]                 out_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0] cnt_after_pop;
  logic          pop, load;

  // The output register mirrors mem[rd_ptr]; it counts as one of the DEPTH entries.
  assign pop           = out_vld & pop_rdy;
  assign rd_nxt        = rd_ptr + AW'(pop);
  assign cnt_after_pop = count - CW'(pop);
  assign load          = (!out_vld || pop) && (cnt_after_pop != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      count  <= count + CW'(push) - CW'(pop);
      if (load) begin
        out_vld <= 1'b1;
        out_dat <= mem[rd_nxt];
      end else if (pop) begin
        out_vld <= 1'b0;
      end
    end
  end
endmodule

module pe_lane_stream_bridge #(
  parameter int NUM_LANES = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_LANES-1:0]          sys__pe__valid,
  input  logic [2*NUM_LANES-1:0]        sys__pe__cntl,
  input  logic [DATA_W*NUM_LANES-1:0]   sys__pe__data,
  output logic [NUM_LANES-1:0]          pe__sys__ready,
  output logic [NUM_LANES-1:0]          pe__lane__valid,
  output logic [2*NUM_LANES-1:0]        pe__lane__cntl,
  output logic [DATA_W*NUM_LANES-1:0]   pe__lane__data,
  input  logic [NUM_LANES-1:0]          lane__pe__ready,
  input  logic [NUM_LANES-1:0]          oob__lane_enable,
  input  logic                          oob__err_clear,
  output logic [NUM_LANES-1:0]          pe__oob__err
`ifdef PE_LANE_BRIDGE_STATS_EN
  ,
  output logic [16*NUM_LANES-1:0]       pe__oob__stream_cnt
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [1:0] C_SOD = 2'b00, C_MOD = 2'b01, C_EOD = 2'b10, C_SOD_EOD = 2'b11;

  typedef enum logic {S_IDLE, S_IN_STREAM} frm_state_t;

  logic [NUM_LANES-1:0] en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) en_q <= '0;
    else          en_q <= oob__lane_enable;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [1:0]        in_cntl;
    logic [CW-1:0]     count;
    logic              accept, bad, push, out_vld, err_q;
    logic [DATA_W+1:0] out_dat;
    frm_state_t        state;

    assign in_cntl           = sys__pe__cntl[2*i +: 2];
    assign pe__sys__ready[i] = en_q[i] && (count < FULL);
    assign accept            = sys__pe__valid[i] && pe__sys__ready[i];
    assign bad               = (state == S_IDLE) ? (in_cntl == C_MOD || in_cntl == C_EOD)
                                                 : (in_cntl == C_SOD || in_cntl == C_SOD_EOD);
    // Framing violations complete the handshake but never reach the FIFO.
    assign push              = accept && !bad;

    pe_lane_fifo #(.W(DATA_W + 2), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (!en_q[i]),
      .push     (push),
      .push_dat ({in_cntl, sys__pe__data[DATA_W*i +: DATA_W]}),
      .pop_rdy  (lane__pe__ready[i] && en_q[i]),
      .out_vld  (out_vld),
      .out_dat  (out_dat),
      .count    (count)
    );

    assign pe__lane__valid[i]                 = out_vld && en_q[i];
    assign pe__lane__cntl[2*i +: 2]           = out_dat[DATA_W +: 2];
    assign pe__lane__data[DATA_W*i +: DATA_W] = out_dat[DATA_W-1:0];
    assign pe__oob__err[i]                    = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= S_IDLE;
        err_q <= 1'b0;
      end else begin
        if (!en_q[i])
          state <= S_IDLE;
        else if (push)
          state <= (in_cntl == C_SOD) ? S_IN_STREAM :
                   (in_cntl == C_EOD) ? S_IDLE : state;
        // A new error outranks a same-cycle clear.
        if (accept && bad)       err_q <= 1'b1;
        else if (oob__err_clear) err_q <= 1'b0;
      end
    end

`ifdef PE_LANE_BRIDGE_STATS_EN
    logic [15:0] stream_cnt;
    assign pe__oob__stream_cnt[16*i +: 16] = stream_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        stream_cnt <= '0;
      else if (!en_q[i])
        stream_cnt <= '0;
      else if (push && (in_cntl == C_EOD || in_cntl == C_SOD_EOD))
        stream_cnt <= stream_cnt + 16'd1;
    end
`endif
  end
endmodule

// File: tb/tb_pe_lane_stream_bridge.sv
// Directed bench for pe_lane_stream_bridge: 4 lanes, depth 4; framing, backpressure, enable flush, async reset.
module tb_pe_lane_stream_bridge;
  localparam int NL = 4, DW = 32, DP = 4;
  localparam logic [1:0] SOD = 2'b00, MOD = 2'b01, EOD = 2'b10, SDE = 2'b11;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NL-1:0]     sys__pe__valid;
  logic [2*NL-1:0]   sys__pe__cntl;
  logic [DW*NL-1:0]  sys__pe__data;
  logic [NL-1:0]     pe__sys__ready;
  logic [NL-1:0]     pe__lane__valid;
  logic [2*NL-1:0]   pe__lane__cntl;
  logic [DW*NL-1:0]  pe__lane__data;
  logic [NL-1:0]     lane__pe__ready;
  logic [NL-1:0]     oob__lane_enable;
  logic              oob__err_clear;
  logic [NL-1:0]     pe__oob__err;
`ifdef PE_LANE_BRIDGE_STATS_EN
  logic [16*NL-1:0]  stream_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_lane_stream_bridge #(.NUM_LANES(NL), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sys__pe__valid   (sys__pe__valid),
    .sys__pe__cntl    (sys__pe__cntl),
    .sys__pe__data    (sys__pe__data),
    .pe__sys__ready   (pe__sys__ready),
    .pe__lane__valid  (pe__lane__valid),
    .pe__lane__cntl   (pe__lane__cntl),
    .pe__lane__data   (pe__lane__data),
    .lane__pe__ready  (lane__pe__ready),
    .oob__lane_enable (oob__lane_enable),
    .oob__err_clear   (oob__err_clear),
    .pe__oob__err     (pe__oob__err)
`ifdef PE_LANE_BRIDGE_STATS_EN
    ,
    .pe__oob__stream_cnt (stream_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input int ln, input logic v, input logic [1:0] c, input logic [31:0] d);
    sys__pe__valid[ln]        = v;
    sys__pe__cntl[2*ln +: 2]  = c;
    sys__pe__data[DW*ln +: DW] = d;
  endtask

  task automatic chk_word(input string tag, input int ln, input logic [1:0] c, input logic [31:0] d);
    chk({tag, "_vld"}, 128'(pe__lane__valid[ln]), 128'(1'b1));
    chk({tag, "_cntl"}, 128'(pe__lane__cntl[2*ln +: 2]), 128'(c));
    chk({tag, "_dat"}, 128'(pe__lane__data[DW*ln +: DW]), 128'(d));
  endtask

  initial begin
    reset_n = 1'b0;
    sys__pe__valid = '0; sys__pe__cntl = '0; sys__pe__data = '0;
    lane__pe__ready = '0; oob__lane_enable = '0; oob__err_clear = 1'b0;
    tick(); tick();
    chk("rst_ready", 128'(pe__sys__ready), 128'(0));
    chk("rst_valid", 128'(pe__lane__valid), 128'(0));
    chk("rst_err",   128'(pe__oob__err), 128'(0));
    chk("rst_data",  128'(pe__lane__data), 128'(0));
    chk("rst_cntl",  128'(pe__lane__cntl), 128'(0));

    reset_n = 1'b1;
    oob__lane_enable = 4'hF;
    lane__pe__ready  = 4'b0001;
    chk("en_delay_ready", 128'(pe__sys__ready), 128'(0));
    tick();
    chk("en_ready", 128'(pe__sys__ready), 128'(4'hF));

    // Lane 0: SOD,MOD,MOD,EOD streamed with PE ready high.
    drv(0, 1'b1, SOD, 32'd1); tick();
    chk("l0_lat", 128'(pe__lane__valid[0]), 128'(0));
    drv(0, 1'b1, MOD, 32'd2); tick();
    chk_word("l0_w1", 0, SOD, 32'd1);
    drv(0, 1'b1, MOD, 32'd3); tick();
    chk_word("l0_w2", 0, MOD, 32'd2);
    drv(0, 1'b1, EOD, 32'd4); tick();
    chk_word("l0_w3", 0, MOD, 32'd3);
    drv(0, 1'b0, SOD, 32'd0); tick();
    chk_word("l0_w4", 0, EOD, 32'd4);
    tick();
    chk("l0_drained", 128'(pe__lane__valid[0]), 128'(0));
    chk("l0_err", 128'(pe__oob__err), 128'(0));

    // Lane 1: fill to DEPTH with PE stalled, then a one-cycle pop.
    for (int k = 0; k < 4; k++) begin
      drv(1, 1'b1, (k == 0) ? SOD : MOD, 32'h10 + 32'(k)); tick();
      chk("l1_fill_ready", 128'(pe__sys__ready[1]), 128'(k < 3));
    end
    drv(1, 1'b1, MOD, 32'h14); tick();
    chk("l1_full_ready", 128'(pe__sys__ready[1]), 128'(0));
    chk_word("l1_hold", 1, SOD, 32'h10);
    lane__pe__ready[1] = 1'b1; tick();
    lane__pe__ready[1] = 1'b0;
    chk("l1_ready_back", 128'(pe__sys__ready[1]), 128'(1));
    tick();
    chk("l1_5th_acc", 128'(pe__sys__ready[1]), 128'(0));
    drv(1, 1'b0, SOD, 32'd0);
    lane__pe__ready[1] = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk_word("l1_drain", 1, MOD, 32'h10 + 32'(k)); tick();
    end
    chk("l1_empty", 128'(pe__lane__valid[1]), 128'(0));
    lane__pe__ready[1] = 1'b0;

    // Lane 2: framing errors and clear priority.
    lane__pe__ready[2] = 1'b1;
    drv(2, 1'b1, MOD, 32'h20); tick();
    chk("l2_mod_idle_err", 128'(pe__oob__err), 128'(4'b0100));
    drv(2, 1'b0, SOD, 32'd0); tick();
    chk("l2_mod_dropped", 128'(pe__lane__valid[2]), 128'(0));
    oob__err_clear = 1'b1; tick();
    oob__err_clear = 1'b0;
    chk("l2_clear1", 128'(pe__oob__err), 128'(0));
    drv(2, 1'b1, SOD, 32'h21); tick();
    drv(2, 1'b1, SOD, 32'h22); tick();
    chk_word("l2_sod", 2, SOD, 32'h21);
    chk("l2_sod_in_stream_err", 128'(pe__oob__err), 128'(4'b0100));
    oob__err_clear = 1'b1;
    drv(2, 1'b1, SDE, 32'h24); tick();
    oob__err_clear = 1'b0;
    drv(2, 1'b0, SOD, 32'd0);
    chk("l2_err_beats_clear", 128'(pe__oob__err[2]), 128'(1));
    chk("l2_bad_dropped", 128'(pe__lane__valid[2]), 128'(0));
    oob__err_clear = 1'b1; tick();
    oob__err_clear = 1'b0;
    chk("l2_clear2", 128'(pe__oob__err), 128'(0));
    drv(2, 1'b1, EOD, 32'h23); tick();
    drv(2, 1'b0, SOD, 32'd0); tick();
    chk_word("l2_eod", 2, EOD, 32'h23);
    tick();
    chk("l2_done_vld", 128'(pe__lane__valid[2]), 128'(0));
    chk("l2_done_err", 128'(pe__oob__err), 128'(0));

    // Lane 3: disable with buffered words, then re-enable.
    drv(3, 1'b1, SOD, 32'h30); tick();
    drv(3, 1'b1, MOD, 32'h31); tick();
    drv(3, 1'b1, MOD, 32'h32); tick();
    drv(3, 1'b0, SOD, 32'd0);
    chk_word("l3_buffered", 3, SOD, 32'h30);
    oob__lane_enable = 4'b0111; tick();
    chk("l3_dis_ready", 128'(pe__sys__ready[3]), 128'(0));
    chk("l3_dis_valid", 128'(pe__lane__valid[3]), 128'(0));
    tick();
    oob__lane_enable = 4'hF; tick();
    chk("l3_reen_ready", 128'(pe__sys__ready[3]), 128'(1));
    chk("l3_reen_valid", 128'(pe__lane__valid[3]), 128'(0));
    lane__pe__ready[3] = 1'b1;
    drv(3, 1'b1, SDE, 32'h3F); tick();
    drv(3, 1'b0, SOD, 32'd0); tick();
    chk_word("l3_sde", 3, SDE, 32'h3F);
    chk("l3_err", 128'(pe__oob__err), 128'(0));
    tick();
    chk("l3_no_stale", 128'(pe__lane__valid[3]), 128'(0));

    // Async reset mid-stream on all lanes; lane 1 is still inside a stream.
    lane__pe__ready = '0;
    drv(0, 1'b1, SOD, 32'h40); drv(1, 1'b1, MOD, 32'h41);
    drv(2, 1'b1, SOD, 32'h42); drv(3, 1'b1, SOD, 32'h43);
    tick();
    for (int l = 0; l < NL; l++) drv(l, 1'b1, MOD, 32'h50 + 32'(l));
    tick();
    chk("mid_valid", 128'(pe__lane__valid), 128'(4'hF));
    chk("mid_err", 128'(pe__oob__err), 128'(0));
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 128'(pe__lane__valid), 128'(0));
    chk("arst_ready", 128'(pe__sys__ready), 128'(0));
    chk("arst_data",  128'(pe__lane__data), 128'(0));
    chk("arst_cntl",  128'(pe__lane__cntl), 128'(0));
    for (int l = 0; l < NL; l++) drv(l, 1'b0, SOD, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 128'(pe__sys__ready), 128'(4'hF));
    lane__pe__ready = 4'hF;
    drv(1, 1'b1, SOD, 32'h55); tick();
    drv(1, 1'b0, SOD, 32'd0); tick();
    chk("post_rst_valid", 128'(pe__lane__valid), 128'(4'b0010));
    chk_word("post_rst_sod", 1, SOD, 32'h55);
    chk("post_rst_err", 128'(pe__oob__err), 128'(0));

`ifdef PE_LANE_BRIDGE_STATS_EN
    tick();
    drv(0, 1'b1, SDE, 32'h60); tick();
    drv(0, 1'b1, SOD, 32'h61); tick();
    drv(0, 1'b1, EOD, 32'h62); tick();
    drv(0, 1'b1, SOD, 32'h63); tick();
    drv(0, 1'b1, MOD, 32'h64); tick();
    drv(0, 1'b1, EOD, 32'h65); tick();
    drv(0, 1'b0, SOD, 32'd0); tick();
    chk("stats_l0", 128'(stream_cnt[15:0]), 128'(16'd3));
    chk("stats_l1", 128'(stream_cnt[31:16]), 128'(16'd0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
